// File: rtl/regfile_wb_scoreboard.sv
// regfile_wb_scoreboard
// Issue-hazard scoreboard and writeback arbiter for the 32x64 integer register
// file. It tracks in-flight destination registers, stalls decode on RAW/WAW
// hazards or when too many writes are pending, and merges the ALU and LSU
// writeback streams onto the single register-file write port.
// Optional feature macro: WB_BYPASS_EN. When it is defined, registers being
// written back this cycle are masked out of the hazard check, and the operand
// is forwarded on byp_data.
module regfile_wb_scoreboard #(
    parameter int MAX_PEND = 8,
    parameter int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_rs1_en,
    input  logic        issue_rs2_en,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_en,
    output logic        issue_ready,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_rd,
    input  logic [63:0] alu_wb_data,
    output logic        alu_wb_ready,
    input  logic        lsu_wb_valid,
    input  logic [4:0]  lsu_wb_rd,
    input  logic [63:0] lsu_wb_data,
    output logic        lsu_wb_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [63:0] rf_wdata,
    output logic        byp_rs1_hit,
    output logic        byp_rs2_hit,
    output logic [63:0] byp_data,
    output logic        wb_err
);

    localparam logic [CW-1:0] LP_MAX_PEND = CW'(MAX_PEND);

    logic [31:0]   r_busy;
    logic [CW-1:0] r_pend_cnt;
    logic          r_last_lsu;
    logic          r_wb_err;

    logic          w_alu_gnt;
    logic          w_lsu_gnt;
    logic          w_gnt_any;
    logic [4:0]    w_gnt_rd;
    logic [63:0]   w_gnt_data;
    logic [31:0]   w_byp_mask;
    logic [31:0]   w_busy_chk;
    logic          w_raw;
    logic          w_waw;
    logic          w_full;
    logic          w_fire;
    logic          w_clr;
    logic          w_err_set;
    logic [31:0]   w_set_mask;
    logic [31:0]   w_clr_mask;

    // Round-robin arbitration: on a tie the source that lost last time wins.
    // A lone requester always wins.
    assign w_alu_gnt  = alu_wb_valid & (~lsu_wb_valid | r_last_lsu);
    assign w_lsu_gnt  = lsu_wb_valid & (~alu_wb_valid | ~r_last_lsu);
    assign w_gnt_any  = w_alu_gnt | w_lsu_gnt;
    assign w_gnt_rd   = w_alu_gnt ? alu_wb_rd   : (w_lsu_gnt ? lsu_wb_rd   : 5'd0);
    assign w_gnt_data = w_alu_gnt ? alu_wb_data : (w_lsu_gnt ? lsu_wb_data : 64'd0);

    assign alu_wb_ready = w_alu_gnt;
    assign lsu_wb_ready = w_lsu_gnt;
    assign rf_we        = w_gnt_any & (w_gnt_rd != 5'd0);
    assign rf_rd        = w_gnt_rd;
    assign rf_wdata     = w_gnt_data;

`ifdef WB_BYPASS_EN
    assign w_byp_mask  = rf_we ? (32'd1 << rf_rd) : 32'd0;
    assign byp_rs1_hit = issue_rs1_en & rf_we & (issue_rs1 == rf_rd);
    assign byp_rs2_hit = issue_rs2_en & rf_we & (issue_rs2 == rf_rd);
    assign byp_data    = rf_wdata;
`else
    assign w_byp_mask  = 32'd0;
    assign byp_rs1_hit = 1'b0;
    assign byp_rs2_hit = 1'b0;
    assign byp_data    = 64'd0;
`endif

    // Hazard check works on registered busy bits. The bypass mask is
    // all-zero unless forwarding is built in.
    assign w_busy_chk  = r_busy & ~w_byp_mask;
    assign w_raw       = (issue_rs1_en & w_busy_chk[issue_rs1]) |
                         (issue_rs2_en & w_busy_chk[issue_rs2]);
    assign w_waw       = issue_rd_en & w_busy_chk[issue_rd];
    assign w_full      = (r_pend_cnt >= LP_MAX_PEND);
    assign issue_ready = ~w_raw & ~w_waw & ~w_full;

    assign w_fire      = issue_valid & issue_ready & issue_rd_en & (issue_rd != 5'd0);
    assign w_clr       = rf_we &  r_busy[rf_rd];
    assign w_err_set   = rf_we & ~r_busy[rf_rd];
    assign w_set_mask  = w_fire ? (32'd1 << issue_rd) : 32'd0;
    assign w_clr_mask  = w_clr  ? (32'd1 << rf_rd)    : 32'd0;

    assign wb_err      = r_wb_err;

    // Scoreboard state. Clears are applied before sets, so that a bypassed
    // re-issue of the register being retired leaves it busy. Bit 0 stays clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= 32'd0;
            r_pend_cnt <= '0;
            r_last_lsu <= 1'b1;
            r_wb_err   <= 1'b0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
            case ({w_fire, w_clr})
                2'b10:   r_pend_cnt <= r_pend_cnt + CW'(1);
                2'b01:   r_pend_cnt <= r_pend_cnt - CW'(1);
                default: r_pend_cnt <= r_pend_cnt;
            endcase
            if (w_gnt_any) begin
                r_last_lsu <= w_lsu_gnt;
            end
            if (w_err_set) begin
                r_wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench for regfile_wb_scoreboard. Writeback expectations are queued
// by the stimulus and consumed by a monitor whenever the DUT grants a source.
module tb_regfile_wb_scoreboard;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_rs1_en;
    logic        issue_rs2_en;
    logic [4:0]  issue_rd;
    logic        issue_rd_en;
    logic        issue_ready;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [63:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        lsu_wb_valid;
    logic [4:0]  lsu_wb_rd;
    logic [63:0] lsu_wb_data;
    logic        lsu_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;
    logic        byp_rs1_hit;
    logic        byp_rs2_hit;
    logic [63:0] byp_data;
    logic        wb_err;

    regfile_wb_scoreboard #(.MAX_PEND(8), .CW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rs1_en (issue_rs1_en),
        .issue_rs2_en (issue_rs2_en),
        .issue_rd     (issue_rd),
        .issue_rd_en  (issue_rd_en),
        .issue_ready  (issue_ready),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .alu_wb_ready (alu_wb_ready),
        .lsu_wb_valid (lsu_wb_valid),
        .lsu_wb_rd    (lsu_wb_rd),
        .lsu_wb_data  (lsu_wb_data),
        .lsu_wb_ready (lsu_wb_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .byp_rs1_hit  (byp_rs1_hit),
        .byp_rs2_hit  (byp_rs2_hit),
        .byp_data     (byp_data),
        .wb_err       (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          lsu;
        bit          we;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t q_exp[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Monitor: every grant must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && (alu_wb_ready === 1'b1 || lsu_wb_ready === 1'b1)) begin
            if (q_exp.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_grant: alu=%0b lsu=%0b rd=%0d", alu_wb_ready, lsu_wb_ready, rf_rd);
            end else begin
                mon_e = q_exp.pop_front();
                chk("gnt_alu", {63'd0, alu_wb_ready}, {63'd0, ~mon_e.lsu});
                chk("gnt_lsu", {63'd0, lsu_wb_ready}, {63'd0, mon_e.lsu});
                chk("rf_we",   {63'd0, rf_we},        {63'd0, mon_e.we});
                chk("rf_rd",   {59'd0, rf_rd},        {59'd0, mon_e.rd});
                chk("rf_wdata", rf_wdata,             mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iss(input bit v, input logic [4:0] rs1, input bit e1,
                           input logic [4:0] rs2, input bit e2,
                           input logic [4:0] rd, input bit ed);
        issue_valid  = v;
        issue_rs1    = rs1;
        issue_rs1_en = e1;
        issue_rs2    = rs2;
        issue_rs2_en = e2;
        issue_rd     = rd;
        issue_rd_en  = ed;
    endtask

    task automatic idle_inputs();
        set_iss(0, 0, 0, 0, 0, 0, 0);
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
    endtask

    task automatic push(input bit lsu, input bit we, input logic [4:0] rd, input logic [63:0] data);
        exp_t e;
        e.lsu = lsu; e.we = we; e.rd = rd; e.data = data;
        q_exp.push_back(e);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic issue_one(input logic [4:0] rd);
        set_iss(1, 0, 0, 0, 0, rd, 1);
        @(negedge clk);
        chk("issue_rdy", {63'd0, issue_ready}, 64'd1);
        tick();
        set_iss(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alu_wb(input logic [4:0] rd, input logic [63:0] data);
        alu_wb_valid = 1; alu_wb_rd = rd; alu_wb_data = data;
    endtask

    task automatic lsu_wb(input logic [4:0] rd, input logic [63:0] data);
        lsu_wb_valid = 1; lsu_wb_rd = rd; lsu_wb_data = data;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #2;
        // reset defaults
        @(negedge clk);
        chk("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
        chk("rst_rf_we",       {63'd0, rf_we},       64'd0);
        chk("rst_rf_rd",       {59'd0, rf_rd},       64'd0);
        chk("rst_rf_wdata",    rf_wdata,             64'd0);
        chk("rst_alu_ready",   {63'd0, alu_wb_ready}, 64'd0);
        chk("rst_lsu_ready",   {63'd0, lsu_wb_ready}, 64'd0);
        chk("rst_byp_hit",     {62'd0, byp_rs1_hit, byp_rs2_hit}, 64'd0);
        chk("rst_byp_data",    byp_data,             64'd0);
        chk("rst_wb_err",      {63'd0, wb_err},      64'd0);
        do_reset();

        // RAW stall and release
        issue_one(5);
        set_iss(1, 5, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("raw_stall", {63'd0, issue_ready}, 64'd0);
        tick();
        alu_wb(5, 64'h1234);
        push(0, 1, 5, 64'h1234);
        @(negedge clk);
        chk("raw_wb_cycle_ready", {63'd0, issue_ready}, {63'd0, BYP});
        chk("byp_rs1_hit", {63'd0, byp_rs1_hit}, {63'd0, BYP});
        chk("byp_data", byp_data, BYP ? 64'h1234 : 64'd0);
        tick();
        idle_inputs();
        set_iss(1, 5, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("raw_release", {63'd0, issue_ready}, 64'd1);
        tick();
        idle_inputs();

        // WAW and rs2 RAW on r7, retired by the LSU
        issue_one(7);
        set_iss(1, 0, 0, 0, 0, 7, 1);
        @(negedge clk);
        chk("waw_stall", {63'd0, issue_ready}, 64'd0);
        set_iss(1, 0, 0, 7, 1, 0, 0);
        #1;
        chk("raw_rs2_stall", {63'd0, issue_ready}, 64'd0);
        tick();
        idle_inputs();
        lsu_wb(7, 64'hDEAD_BEEF_0000_0007);
        push(1, 1, 7, 64'hDEAD_BEEF_0000_0007);
        tick();
        idle_inputs();
        set_iss(1, 0, 0, 7, 1, 7, 1);
        @(negedge clk);
        chk("waw_release", {63'd0, issue_ready}, 64'd1);
        chk("no_err_after_retire", {63'd0, wb_err}, 64'd0);
        tick();
        idle_inputs();
        // the issue above fired, so r7 is busy again; cleared by the reset below

        // asynchronous reset mid-run with r5 busy
        issue_one(5);
        set_iss(1, 5, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_reset_stall", {63'd0, issue_ready}, 64'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_ready", {63'd0, issue_ready}, 64'd1);
        chk("async_rst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("async_rst_wb_err", {63'd0, wb_err}, 64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_rs1_5", {63'd0, issue_ready}, 64'd1);
        tick();
        idle_inputs();

        // round robin: ALU wins the first tie after reset
        issue_one(1); issue_one(2); issue_one(3); issue_one(4); issue_one(6);
        alu_wb(1, 64'hA1); lsu_wb(2, 64'hB2); push(0, 1, 1, 64'hA1); tick();
        alu_wb(3, 64'hA3);                    push(1, 1, 2, 64'hB2); tick();
        lsu_wb(4, 64'hB4);                    push(0, 1, 3, 64'hA3); tick();
        alu_wb(6, 64'hA6);                    push(1, 1, 4, 64'hB4); tick();
        lsu_wb_valid = 0;                     push(0, 1, 6, 64'hA6); tick();
        idle_inputs();
        set_iss(1, 6, 1, 1, 1, 4, 1);
        @(negedge clk);
        chk("rr_all_retired", {63'd0, issue_ready}, 64'd1);
        chk("rr_no_err", {63'd0, wb_err}, 64'd0);
        tick();
        idle_inputs();

        // full condition and simultaneous issue + retire
        do_reset();
        for (int i = 10; i < 18; i++) issue_one(5'(i));
        set_iss(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_no_rd", {63'd0, issue_ready}, 64'd0);
        tick();
        alu_wb(10, 64'h10);
        push(0, 1, 10, 64'h10);
        @(negedge clk);
        chk("full_during_wb", {63'd0, issue_ready}, 64'd0);
        tick();
        alu_wb_valid = 0;
        @(negedge clk);
        chk("after_one_retire", {63'd0, issue_ready}, 64'd1);
        tick();
        set_iss(1, 0, 0, 0, 0, 18, 1);
        alu_wb(11, 64'h11);
        push(0, 1, 11, 64'h11);
        @(negedge clk);
        chk("inc_dec_issue_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        idle_inputs();
        set_iss(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("inc_dec_count_kept", {63'd0, issue_ready}, 64'd1);
        tick();
        issue_one(19);
        set_iss(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_again", {63'd0, issue_ready}, 64'd0);
        tick();

        // x0 handling and sticky protocol error
        do_reset();
        issue_one(0);
        set_iss(1, 0, 1, 0, 1, 0, 1);
        @(negedge clk);
        chk("x0_never_busy", {63'd0, issue_ready}, 64'd1);
        tick();
        idle_inputs();
        alu_wb(0, 64'h55);
        push(0, 0, 0, 64'h55);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("x0_wb_no_err", {63'd0, wb_err}, 64'd0);
        tick();
        lsu_wb(9, 64'h99);
        push(1, 1, 9, 64'h99);
        tick();
        idle_inputs();
        set_iss(1, 9, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("err_set", {63'd0, wb_err}, 64'd1);
        chk("err_no_underflow", {63'd0, issue_ready}, 64'd1);
        repeat (3) tick();
        idle_inputs();
        @(negedge clk);
        chk("err_sticky", {63'd0, wb_err}, 64'd1);
        tick();

        repeat (2) tick();
        chk("scoreboard_drained", 64'(q_exp.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
